// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the load/store unit: access size encoding, FSM states,
// alignment check and store lane formatting.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StResp = 2'd2
  } state_e;

  // True for an illegal size or an access not aligned to its own size.
  function automatic logic req_bad(size_e size, logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(size_e size, logic [1:0] off);
    case (size)
      SIZE_B:  return 4'b0001 << off;
      SIZE_H:  return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data so every lane the strobe can select carries it.
  function automatic logic [31:0] store_data(size_e size, logic [31:0] wdata);
    case (size)
      SIZE_B:  return {4{wdata[7:0]}};
      SIZE_H:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_extract.sv
// Load lane selection and sign/zero extension of a memory read word.
module mem_lsu_extract
  import mem_lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend to 32 bits; words pass through untouched.
  always_comb begin
    byte_sel = word_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SIZE_B:  data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      SIZE_H:  data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit in front of a one-cycle-latency memory port.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic [3:0]        mem_wr_o,
  input  logic [31:0]       mem_data_i
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  size_e             size_q;
  logic              uns_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;

  size_e       req_size;
  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic        unused_addr;

  // Address bits above the memory range are dropped so accesses wrap.
  assign unused_addr = ^req_addr_i[31:ADDR_W+2];

  assign req_size     = size_e'(req_size_i);
  assign req_ready_o  = rst_i && (state_q == StIdle);
  assign accept       = req_valid_i && req_ready_o;
  assign req_err      = req_bad(req_size, req_addr_i[1:0]);

  // Memory port: the address is taken live in IDLE so load data returns in READ.
  assign mem_addr_o   = (state_q == StIdle) ? req_addr_i[ADDR_W+1:2] : addr_q;
  assign mem_data_o   = store_data(req_size, req_wdata_i);
  assign mem_wr_o     = (accept && req_we_i && !req_err) ?
                        store_strb(req_size, req_addr_i[1:0]) : 4'b0000;

  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;

  mem_lsu_extract u_extract (
    .word_i     (mem_data_i),
    .addr_i     (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  // Request FSM with registered response outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      off_q        <= 2'b00;
      size_q       <= SIZE_B;
      uns_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q <= req_addr_i[ADDR_W+1:2];
            off_q  <= req_addr_i[1:0];
            size_q <= req_size;
            uns_q  <= req_unsigned_i;
            if (req_err || req_we_i) begin
              // Stores complete in the accept cycle; errors never touch memory.
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_err_q   <= req_err;
              resp_rdata_q <= 32'h0;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_data;
        end
        StResp: begin
          if (resp_ready_i) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, randomized traffic against a
// byte-level reference model, and a mid-transaction reset sequence.
module tb_mem_lsu;

  localparam int unsigned AW    = 14;
  localparam int          WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [31:0]   req_addr_i;
  logic [31:0]   req_wdata_i;
  logic          req_we_i;
  logic [1:0]    req_size_i;
  logic          req_unsigned_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [31:0]   resp_rdata_o;
  logic          resp_err_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_data_o;
  logic [3:0]    mem_wr_o;
  logic [31:0]   mem_data_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(AW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_wr_o       (mem_wr_o),
    .mem_data_i     (mem_data_i)
  );

  function automatic logic [31:0] init_word(int i);
    logic [31:0] v;
    v = 32'(i);
    if (i == 1) return 32'h8899AABB;
    return (v * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  // Memory with one-cycle read latency and byte strobes; reloaded while in reset.
  always @(posedge clk) begin
    if (!rst_i) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wr_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
    end
    mem_data_i <= mem[mem_addr_o];
  end

  task automatic ref_init();
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, size in bytes, alignment by modulo.
  task automatic model(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic [1:0] size, input logic uns,
                       output logic [31:0] e_rdata, output logic e_err, output int e_lat,
                       output logic [3:0] e_wr, output logic [31:0] e_dat);
    int nb, off, idx;
    logic [31:0] word, mask;
    nb  = 1 << size;
    off = int'(addr % 4);
    idx = int'((addr >> 2) % WORDS);
    e_err   = (size == 2'd3) || ((off % nb) != 0);
    e_rdata = 32'h0;
    e_wr    = 4'b0;
    e_dat   = 32'h0;
    if (e_err) begin
      e_lat = 1;
    end else if (we) begin
      e_lat = 1;
      for (int l = 0; l < 4; l++) e_dat[8*l +: 8] = wdata[8*(l % nb) +: 8];
      for (int b = 0; b < nb; b++) begin
        e_wr[off+b] = 1'b1;
        ref_mem[idx][8*(off+b) +: 8] = wdata[8*b +: 8];
      end
    end else begin
      e_lat = 2;
      word  = ref_mem[idx] >> (8 * off);
      if (nb == 4) begin
        e_rdata = word;
      end else begin
        mask    = (32'd1 << (8 * nb)) - 32'd1;
        e_rdata = word & mask;
        if (!uns && e_rdata[8*nb-1]) e_rdata = e_rdata | ~mask;
      end
    end
  endtask

  // Random request inputs while busy; the DUT must ignore them.
  task automatic noise();
    req_valid_i    = 1'($urandom);
    req_addr_i     = $urandom;
    req_wdata_i    = $urandom;
    req_we_i       = 1'($urandom);
    req_size_i     = 2'($urandom);
    req_unsigned_i = 1'($urandom);
  endtask

  task automatic run_req(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [1:0] size, input logic uns, input int hold,
                         input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                         input logic [3:0] e_wr, input logic [31:0] e_dat);
    int lat;
    bit seen;
    req_valid_i    = 1'b1;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    #1;
    chk({tag, " ready_at_accept"}, 32'(req_ready_o), 32'd1);
    chk({tag, " wr_at_accept"}, 32'(mem_wr_o), 32'(e_wr));
    if (e_wr != 4'b0) chk({tag, " wdata_lanes"}, mem_data_o, e_dat);
    @(posedge clk); #1;
    noise();
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 8) begin
      lat++;
      @(negedge clk);
      chk({tag, " wr_after_accept"}, 32'(mem_wr_o), 32'd0);
      if (resp_valid_o) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        noise();
      end
    end
    chk({tag, " resp_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " rdata"}, resp_rdata_o, e_rdata);
    chk({tag, " err"}, 32'(resp_err_o), 32'(e_err));
    chk({tag, " ready_busy"}, 32'(req_ready_o), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      noise();
      @(negedge clk);
      chk({tag, " hold_valid"}, 32'(resp_valid_o), 32'd1);
      chk({tag, " hold_rdata"}, resp_rdata_o, e_rdata);
      chk({tag, " hold_err"}, 32'(resp_err_o), 32'(e_err));
      chk({tag, " hold_ready"}, 32'(req_ready_o), 32'd0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    req_valid_i  = 1'b0;
    @(negedge clk);
    chk({tag, " valid_after_hs"}, 32'(resp_valid_o), 32'd0);
    chk({tag, " idle_after_hs"}, 32'(req_ready_o), 32'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    int          hold;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [3:0]  wr;
    logic [31:0] dat;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] m_rdata, m_dat, a, wd;
    logic        m_err, we, uns;
    logic [1:0]  sz;
    logic [3:0]  m_wr;
    int          m_lat;

    vecs[0]  = '{32'h5,     32'h0,        1'b0, 2'd0, 1'b0, 0, 32'hFFFFFFAA, 1'b0, 2, 4'b0000, 32'h0};
    vecs[1]  = '{32'h6,     32'h0,        1'b0, 2'd1, 1'b1, 0, 32'h00008899, 1'b0, 2, 4'b0000, 32'h0};
    vecs[2]  = '{32'h6,     32'h0,        1'b0, 2'd1, 1'b0, 0, 32'hFFFF8899, 1'b0, 2, 4'b0000, 32'h0};
    vecs[3]  = '{32'h7,     32'h12345678, 1'b1, 2'd0, 1'b0, 0, 32'h0,        1'b0, 1, 4'b1000, 32'h78787878};
    vecs[4]  = '{32'h4,     32'h0,        1'b0, 2'd2, 1'b0, 3, 32'h7899AABB, 1'b0, 2, 4'b0000, 32'h0};
    vecs[5]  = '{32'h2,     32'h0,        1'b0, 2'd2, 1'b0, 0, 32'h0,        1'b1, 1, 4'b0000, 32'h0};
    vecs[6]  = '{32'h6,     32'hCAFEBEEF, 1'b1, 2'd1, 1'b0, 1, 32'h0,        1'b0, 1, 4'b1100, 32'hBEEFBEEF};
    vecs[7]  = '{32'h6,     32'h0,        1'b0, 2'd1, 1'b1, 0, 32'h0000BEEF, 1'b0, 2, 4'b0000, 32'h0};
    vecs[8]  = '{32'h7,     32'h0,        1'b0, 2'd0, 1'b1, 0, 32'h000000BE, 1'b0, 2, 4'b0000, 32'h0};
    vecs[9]  = '{32'h4,     32'h0,        1'b0, 2'd0, 1'b0, 0, 32'hFFFFFFBB, 1'b0, 2, 4'b0000, 32'h0};
    vecs[10] = '{32'h5,     32'hFFFFFFFF, 1'b1, 2'd1, 1'b0, 0, 32'h0,        1'b1, 1, 4'b0000, 32'h0};
    vecs[11] = '{32'h4,     32'h0,        1'b0, 2'd3, 1'b0, 0, 32'h0,        1'b1, 1, 4'b0000, 32'h0};
    vecs[12] = '{32'h10004, 32'h11223344, 1'b1, 2'd2, 1'b0, 0, 32'h0,        1'b0, 1, 4'b1111, 32'h11223344};
    vecs[13] = '{32'h4,     32'h0,        1'b0, 2'd2, 1'b1, 0, 32'h11223344, 1'b0, 2, 4'b0000, 32'h0};

    ref_init();
    rst_i          = 1'b0;
    resp_ready_i   = 1'b0;
    req_valid_i    = 1'b1;
    req_addr_i     = 32'h4;
    req_wdata_i    = 32'hFFFFFFFF;
    req_we_i       = 1'b1;
    req_size_i     = 2'd2;
    req_unsigned_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(req_ready_o), 32'd0);
    chk("rst resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst rdata", resp_rdata_o, 32'h0);
    chk("rst err", 32'(resp_err_o), 32'd0);
    chk("rst wr", 32'(mem_wr_o), 32'd0);
    req_valid_i = 1'b0;
    rst_i       = 1'b1;
    #1;
    chk("release ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      model(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].size, vecs[i].uns,
            m_rdata, m_err, m_lat, m_wr, m_dat);
      run_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].size,
              vecs[i].uns, vecs[i].hold, vecs[i].rdata, vecs[i].err, vecs[i].lat, vecs[i].wr,
              vecs[i].dat);
    end

    for (int i = 0; i < 200; i++) begin
      a   = ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 63));
      wd  = $urandom;
      we  = 1'($urandom);
      sz  = 2'($urandom);
      uns = 1'($urandom);
      model(a, wd, we, sz, uns, m_rdata, m_err, m_lat, m_wr, m_dat);
      run_req($sformatf("rnd%0d", i), a, wd, we, sz, uns, $urandom_range(0, 2),
              m_rdata, m_err, m_lat, m_wr, m_dat);
    end

    // Reset while a load sits in READ: the transaction is dropped.
    req_valid_i    = 1'b1;
    req_addr_i     = 32'h4;
    req_we_i       = 1'b0;
    req_size_i     = 2'd2;
    req_unsigned_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("midrst in_read valid", 32'(resp_valid_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("midrst valid", 32'(resp_valid_o), 32'd0);
    chk("midrst ready", 32'(req_ready_o), 32'd0);
    chk("midrst rdata", resp_rdata_o, 32'h0);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("midrst release ready", 32'(req_ready_o), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("midrst no_late_resp", 32'(resp_valid_o), 32'd0);
    end
    ref_init();
    run_req("post_rst", 32'h4, 32'h0, 1'b0, 2'd2, 1'b0, 0, 32'h8899AABB, 1'b0, 2, 4'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, giving the width of the memory word address.
REQ-002 SHALL have port clk_i  input  1  clock; all logic on the rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  1  core request valid.
REQ-005 SHALL have port req_ready_o  output  1  request accepted when valid&&ready.
REQ-006 SHALL have port req_addr_i  input  32  byte address.
REQ-007 SHALL have port req_wdata_i  input  32  store data, right-aligned.
REQ-008 SHALL have port req_we_i  input  1  1=store, 0=load.
REQ-009 SHALL have port req_size_i  input  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-010 SHALL have port req_unsigned_i  input  1  zero-extend load data.
REQ-011 SHALL have port resp_valid_o  output  1  response valid.
REQ-012 SHALL have port resp_ready_i  input  1  response consumed when valid&&ready.
REQ-013 SHALL have port resp_rdata_o  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err_o  output  1  misaligned or illegal-size request.
REQ-015 SHALL have ports mem_addr_o (output, ADDR_W, word address), mem_data_o (output, 32, write data), mem_wr_o (output, 4, byte strobes) and mem_data_i (input, 32), driving one memory port whose read data appears one cycle after the address.

Function
REQ-016 SHALL implement FSM states IDLE, READ and RESP, with req_ready_o=1 only in IDLE while rst_i=1.
REQ-017 SHALL, on accept, detect an error when size=3, size=1 with addr[0]=1, or size=2 with addr[1:0]!=0, then go to RESP with err=1, rdata=0 and mem_wr_o=0.
REQ-018 SHALL, on accepting an aligned store, drive mem_wr_o combinationally in the accept cycle only and go to RESP with rdata=0, giving a response one cycle after accept.
REQ-019 SHALL use store strobes: byte 4'b0001<<addr[1:0]; half 4'b0011 or 4'b1100 by addr[1]; word 4'b1111.
REQ-020 SHALL replicate store data across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-021 SHALL, on accepting an aligned load, go IDLE->READ, capture the extracted mem_data_i in READ into the response register, then go READ->RESP, giving a response two cycles after accept.
REQ-022 SHALL extract loads by the lane selected by addr[1:0], sign-extending when req_unsigned_i=0 and zero-extending otherwise; the word size ignores the unsigned flag.
REQ-023 SHALL drive mem_addr_o from req_addr_i[ADDR_W+1:2] in IDLE and from the latched address otherwise; higher address bits are ignored, so addresses wrap.
REQ-024 SHALL hold resp_valid_o, resp_rdata_o and resp_err_o stable in RESP until resp_ready_i=1, then return to IDLE; there is no accept in the same cycle, so a new request needs at least one IDLE cycle.
REQ-025 SHALL assert mem_wr_o only in the accept cycle of an aligned store; mem_wr_o is 0 in all other cycles.
REQ-026 SHALL latch address, size and unsigned flag only on accept, and SHALL ignore request inputs in READ and RESP.

Reset
REQ-027 SHALL, while rst_i=0, force state to IDLE, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, req_ready_o=0, mem_wr_o=0, and clear the latched address to 0.
REQ-028 SHALL, on reset asserted mid-operation in READ or RESP, discard the transaction, with no response produced after reset release.
REQ-029 SHALL set req_ready_o=1 in the first cycle after rst_i returns high.

Structure
REQ-030 SHALL place the size encoding (enum SIZE_B/SIZE_H/SIZE_W) and the FSM state enum in package mem_lsu_pkg.
REQ-031 SHALL isolate load lane selection and extension in one combinational sub-module, mem_lsu_extract (inputs: word, addr[1:0], size, unsigned; output: 32-bit data).

Verification
(Memory preloaded with word 1, byte address 0x4, = 0x8899AABB.)
REQ-032 SHALL cover: load byte signed at 0x5 -> rdata 0xFFFFFFAA, err=0, resp_valid exactly 2 cycles after accept.
REQ-033 SHALL cover: load half unsigned at 0x6 -> rdata 0x00008899; load half signed at 0x6 -> 0xFFFF8899.
REQ-034 SHALL cover: store byte wdata 0x12345678 at 0x7 -> mem_wr_o=4'b1000, mem_data_o=0x78787878 in the accept cycle, response 1 cycle later; a following word load at 0x4 -> 0x7899AABB.
REQ-035 SHALL cover: word load at 0x2 -> err=1, rdata=0, mem_wr_o=0 throughout, response 1 cycle after accept.
REQ-036 SHALL cover: resp_ready_i held low 3 cycles -> response fields stable and req_ready_o=0 throughout; state is IDLE one cycle after resp_ready_i=1.
REQ-037 SHALL cover: rst_i low during READ -> resp_valid_o=0 the next cycle and no late response; req_ready_o=1 in the first cycle after release.
